// File: rtl/mult32x32_arb.sv
// Two-requester arbiter in front of one shared mult32x32 (Moore FSM, sync active-low reset).
// Define MULT_ARB_RR_EN for round-robin arbitration; default build is fixed priority (requester 0 wins).
module mult32x32_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        done0,
    output logic        done1,
    output logic [63:0] result,
    output logic        arb_busy,
    output logic        m_start,
    output logic [31:0] m_a,
    output logic [31:0] m_b,
    input  logic        m_busy,
    input  logic [63:0] m_product
);
    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [OP_W-1:0]     m_a_q, m_a_d;
    logic [OP_W-1:0]     m_b_q, m_b_d;
    logic [PROD_W-1:0]   result_q, result_d;
    logic                grant1;

`ifdef MULT_ARB_RR_EN
    // rr_q=0 prefers requester 0 on a tie, rr_q=1 prefers requester 1
    logic                rr_q, rr_d;
    assign grant1 = req1 & (~req0 | rr_q);
`else
    assign grant1 = req1 & ~req0;
`endif

    // Next-state and datapath capture
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        m_a_d    = m_a_q;
        m_b_d    = m_b_q;
        result_d = result_q;
`ifdef MULT_ARB_RR_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant1;
                    m_a_d   = grant1 ? a1 : a0;
                    m_b_d   = grant1 ? b1 : b0;
                    state_d = ISSUE;
`ifdef MULT_ARB_RR_EN
                    rr_d    = ~grant1;
`endif
                end
            end
            ISSUE:     state_d = WAIT_RISE;
            WAIT_RISE: if (m_busy) state_d = WAIT_FALL;
            WAIT_FALL: begin
                if (!m_busy) begin
                    result_d = m_product;
                    state_d  = RESP;
                end
            end
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            m_a_q    <= OP_W'(0);
            m_b_q    <= OP_W'(0);
            result_q <= PROD_W'(0);
`ifdef MULT_ARB_RR_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            m_a_q    <= m_a_d;
            m_b_q    <= m_b_d;
            result_q <= result_d;
`ifdef MULT_ARB_RR_EN
            rr_q     <= rr_d;
`endif
        end
    end

    // Strobes decoded from registered state only
    assign m_start  = (state_q == ISSUE);
    assign done0    = (state_q == RESP) && !owner_q;
    assign done1    = (state_q == RESP) && owner_q;
    assign arb_busy = (state_q != IDLE);
    assign result   = result_q;
    assign m_a      = m_a_q;
    assign m_b      = m_b_q;

endmodule

// File: doc/mult32x32_arb.md
MULT32X32_ARB -- requirements
Module: mult32x32_arb

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits and product width at 64 bits.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 req0 / req1  in  1 each  requester 0/1 requests a multiplication; held high until its done pulse.
REQ-005 a0, b0 / a1, b1  in  32 each  requester operands; valid while the matching req is high.
REQ-006 done0 / done1  out  1 each  one-cycle pulse: the result for that requester is valid on result.
REQ-007 result  out  64  last captured product; holds its value until the next capture.
REQ-008 arb_busy  out  1  high whenever state != IDLE.
REQ-009 m_start  out  1  start pulse to the shared mult32x32.
REQ-010 m_a, m_b  out  32 each  operands to the multiplier; registered.
REQ-011 m_busy  in  1  busy from the multiplier.
REQ-012 m_product  in  64  product from the multiplier.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT_RISE, WAIT_FALL and RESP; all outputs are registered or decoded from state only (Moore).
REQ-014 IDLE: with any req high, on the edge the FSM SHALL select a winner, latch its a/b into m_a/m_b, record the owner and go to ISSUE; with no req high it stays in IDLE.
REQ-015 ISSUE: m_start=1 for exactly one cycle, then the FSM SHALL go to WAIT_RISE.
REQ-016 WAIT_RISE: the FSM SHALL stay until m_busy=1, then go to WAIT_FALL.
REQ-017 WAIT_FALL: the FSM SHALL stay while m_busy=1; on m_busy=0 it captures m_product into result and goes to RESP.
REQ-018 RESP: done of the owner SHALL be 1 for one cycle (the other done stays 0), then the FSM returns to IDLE.
REQ-019 m_a/m_b SHALL stay stable from ISSUE through RESP, because the multiplier reads its operands over many cycles.
REQ-020 Latency: req seen in IDLE at edge k -> m_start high in cycle k+1 -> done one cycle after the capture edge. Minimum turnaround is busy duration + 4 cycles.
REQ-021 Requests are ignored outside IDLE; req changes and operand changes mid-operation SHALL NOT affect the running operation.
REQ-022 A requester that drops req mid-operation SHALL still receive its done pulse and result.
REQ-023 A req still high in the first IDLE cycle after RESP SHALL be treated as a new request.
REQ-024 Simultaneous req0 and req1 in IDLE SHALL be resolved by the arbitration policy in REQ-028/REQ-029.
REQ-025 The unselected requester waits; it is never dropped while its req stays high.

Reset
REQ-026 While reset=0 at a rising edge, the block SHALL set: state=IDLE; m_start=0; done0=done1=0; result=0; m_a=m_b=0; owner=0; round-robin pointer=0 (requester 0 preferred next).
REQ-027 Reset asserted mid-operation SHALL abort it with no done pulse; the multiplier is reset by the same signal.

Configuration
REQ-028 With MULT_ARB_RR_EN defined: round-robin arbitration; on every grant the pointer SHALL move to prefer the non-granted requester next; a lone requester is always granted.
REQ-029 Without MULT_ARB_RR_EN: fixed priority, requester 0 always wins ties; no pointer register SHALL exist.

Verification
REQ-030 Single request: req0, a0=7, b0=6, multiplier model busy 8 cycles -> one m_start pulse, m_a=7, m_b=6, done0 once, result=42, done1 never.
REQ-031 Tie with MULT_ARB_RR_EN: req0 and req1 held continuously, a0=b0=3, a1=b1=5 -> grants alternate 0,1,0,1; results 9,25,9,25.
REQ-032 Tie without MULT_ARB_RR_EN: same stimulus -> requester 0 is always granted; requester 1 is granted only after req0 drops.
REQ-033 Operand stability: a0 changed to 0xFFFFFFFF during WAIT_FALL for a 0x10000 x 0x10000 operation -> m_a unchanged, result=0x0000000100000000.
REQ-034 Reset mid-operation: reset=0 for 1 cycle during WAIT_FALL -> IDLE next cycle, m_start=0, result=0, no done pulse, arb_busy=0.
REQ-035 Maximum operands: a0=b0=0xFFFFFFFF -> result=0xFFFFFFFE00000001, and req0 held after done0 is re-granted in the next IDLE cycle.
